// File: rtl/regfile_leitura_escrita_if.sv
// Register-file bus: two read ports, one write port and the serial dump stream.
// Reads are combinational; writes and dump output update on the clock edge.
// No backpressure: dump_valid is a strobe that the consumer must take each cycle.
interface regfile_leitura_escrita_if #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 5
);
    logic [ADDR-1:0]  ReadRegister1;
    logic [ADDR-1:0]  ReadRegister2;
    logic [ADDR-1:0]  WriteRegister;
    logic [WIDTH-1:0] WriteData;
    logic             RegWrite;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;
    logic             dump_req;
    logic             dump_busy;
    logic             dump_valid;
    logic [ADDR-1:0]  dump_addr;
    logic [WIDTH-1:0] dump_data;

    modport master (
        output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, dump_req,
        input  ReadData1, ReadData2, dump_busy, dump_valid, dump_addr, dump_data
    );

    modport slave (
        input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, dump_req,
        output ReadData1, ReadData2, dump_busy, dump_valid, dump_addr, dump_data
    );
endinterface

// File: rtl/regfile_leitura_escrita.sv
// 32-entry MIPS register file with serial dump engine; REGFILE_BYPASS_EN enables write-to-read forwarding.
// Latency: reads 0 cycles, writes visible after the edge; dump streams DEPTH entries starting one edge after dump_req.
// No backpressure: dump_req is ignored while a dump is running; dump output cannot be stalled.
module regfile_leitura_escrita #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 5
) (
    input logic                      clock,
    input logic                      reset,
    regfile_leitura_escrita_if.slave rf
);
    localparam int DEPTH = 1 << ADDR;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] DUMP = 1'b1;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [0:0]       state;
    logic [ADDR-1:0]  idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.RegWrite && (rf.WriteRegister != '0)) begin
            regs[rf.WriteRegister] <= rf.WriteData;
        end
    end

    always_comb begin
        rf.ReadData1 = regs[rf.ReadRegister1];
        rf.ReadData2 = regs[rf.ReadRegister2];
`ifdef REGFILE_BYPASS_EN
        if (rf.RegWrite && (rf.WriteRegister != '0) && (rf.WriteRegister == rf.ReadRegister1)) begin
            rf.ReadData1 = rf.WriteData;
        end
        if (rf.RegWrite && (rf.WriteRegister != '0) && (rf.WriteRegister == rf.ReadRegister2)) begin
            rf.ReadData2 = rf.WriteData;
        end
`endif
        // Index 0 is hardwired to zero regardless of storage or forwarding.
        if (rf.ReadRegister1 == '0) begin
            rf.ReadData1 = '0;
        end
        if (rf.ReadRegister2 == '0) begin
            rf.ReadData2 = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            rf.dump_busy  <= 1'b0;
            rf.dump_valid <= 1'b0;
            rf.dump_addr  <= '0;
            rf.dump_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rf.dump_valid <= 1'b0;
                    if (rf.dump_req) begin
                        state        <= DUMP;
                        idx          <= '0;
                        rf.dump_busy <= 1'b1;
                    end
                end
                default: begin
                    // dump_data captures the pre-edge value even if a write hits idx now.
                    rf.dump_valid <= 1'b1;
                    rf.dump_addr  <= idx;
                    rf.dump_data  <= regs[idx];
                    idx           <= idx + ADDR'(1);
                    if (idx == ADDR'(DEPTH - 1)) begin
                        state        <= IDLE;
                        rf.dump_busy <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_leitura_escrita.sv
// Self-checking bench for regfile_leitura_escrita: vector table for reads, queue scoreboard for the dump stream.
module tb_regfile_leitura_escrita;
    localparam int WIDTH = 32;
    localparam int ADDR  = 5;
    localparam int DEPTH = 32;

    typedef struct {
        logic [ADDR-1:0]  r1;
        logic [ADDR-1:0]  r2;
        logic [WIDTH-1:0] e1;
        logic [WIDTH-1:0] e2;
    } rd_vec_t;

    typedef struct {
        logic [ADDR-1:0]  addr;
        logic [WIDTH-1:0] data;
    } dump_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    logic [WIDTH-1:0] model [DEPTH];
    dump_t            exp_q [$];
    rd_vec_t          vec [6];

    always #5 clock = ~clock;

    regfile_leitura_escrita_if #(.WIDTH(WIDTH), .ADDR(ADDR)) rf ();

    regfile_leitura_escrita #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
        .clock (clock),
        .reset (reset),
        .rf    (rf)
    );

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [ADDR-1:0] idx, input logic [WIDTH-1:0] data);
        rf.RegWrite      = 1'b1;
        rf.WriteRegister = idx;
        rf.WriteData     = data;
        tick();
        rf.RegWrite = 1'b0;
        if (idx != '0) model[idx] = data;
    endtask

    task automatic push_dump();
        for (int i = 0; i < DEPTH; i++) begin
            dump_t e;
            e.addr = ADDR'(i);
            e.data = model[i];
            exp_q.push_back(e);
        end
    endtask

    // Compare one dump beat against the scoreboard, if the DUT produced one.
    task automatic dump_step();
        dump_t e;
        if (rf.dump_valid) begin
            if (exp_q.size() == 0) begin
                check("dump_unexpected_valid", WIDTH'(rf.dump_valid), '0);
            end else begin
                e = exp_q.pop_front();
                check("dump_addr", WIDTH'(rf.dump_addr), WIDTH'(e.addr));
                check("dump_data", rf.dump_data, e.data);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            rf.ReadRegister1 = ADDR'(i);
            rf.ReadRegister2 = ADDR'(DEPTH - 1 - i);
            #1;
            check({name, "_rd1"}, rf.ReadData1, '0);
            check({name, "_rd2"}, rf.ReadData2, '0);
        end
    endtask

    initial begin
        int n;
        int nvalid;
        logic [WIDTH-1:0] exp_byp;

        vec[0] = '{r1: 5'd0,  r2: 5'd1,  e1: 32'd0,  e2: 32'd3};
        vec[1] = '{r1: 5'd8,  r2: 5'd9,  e1: 32'd24, e2: 32'd27};
        vec[2] = '{r1: 5'd31, r2: 5'd30, e1: 32'd93, e2: 32'd90};
        vec[3] = '{r1: 5'd5,  r2: 5'd5,  e1: 32'd15, e2: 32'd15};
        vec[4] = '{r1: 5'd16, r2: 5'd0,  e1: 32'd48, e2: 32'd0};
        vec[5] = '{r1: 5'd2,  r2: 5'd17, e1: 32'd6,  e2: 32'd51};

        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        reset            = 1'b1;
        rf.ReadRegister1 = '0;
        rf.ReadRegister2 = '0;
        rf.WriteRegister = '0;
        rf.WriteData     = '0;
        rf.RegWrite      = 1'b0;
        rf.dump_req      = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_dump_busy",  WIDTH'(rf.dump_busy),  '0);
        check("rst_dump_valid", WIDTH'(rf.dump_valid), '0);
        check("rst_dump_addr",  WIDTH'(rf.dump_addr),  '0);
        check("rst_dump_data",  rf.dump_data,          '0);
        check_all_zero("rst");

        wr(5'd8, 32'h0000_00AB);
        rf.ReadRegister2 = 5'd8;
        #1;
        check("write8_rd2", rf.ReadData2, 32'h0000_00AB);
        wr(5'd0, 32'hFFFF_FFFF);
        rf.ReadRegister1 = 5'd0;
        #1;
        check("write0_rd1", rf.ReadData1, '0);

        // Same-cycle read of the register being written.
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'd123;
`else
        exp_byp = 32'd0;
`endif
        rf.RegWrite      = 1'b1;
        rf.WriteRegister = 5'd9;
        rf.WriteData     = 32'd123;
        rf.ReadRegister1 = 5'd9;
        rf.ReadRegister2 = 5'd9;
        #1;
        check("bypass_rd1", rf.ReadData1, exp_byp);
        check("bypass_rd2", rf.ReadData2, exp_byp);
        tick();
        rf.RegWrite = 1'b0;
        model[9] = 32'd123;
        #1;
        check("after_edge_rd1", rf.ReadData1, 32'd123);
        check("after_edge_rd2", rf.ReadData2, 32'd123);

        for (int i = 1; i < DEPTH; i++) wr(ADDR'(i), WIDTH'(i * 3));
        for (int i = 0; i < 6; i++) begin
            rf.ReadRegister1 = vec[i].r1;
            rf.ReadRegister2 = vec[i].r2;
            #1;
            check($sformatf("vec%0d_rd1", i), rf.ReadData1, vec[i].e1);
            check($sformatf("vec%0d_rd2", i), rf.ReadData2, vec[i].e2);
        end

        // Single-pulse dump with a colliding write to index 5.
        rf.dump_req = 1'b1;
        tick();
        rf.dump_req = 1'b0;
        check("dump_start_busy",  WIDTH'(rf.dump_busy),  32'd1);
        check("dump_start_valid", WIDTH'(rf.dump_valid), '0);
        push_dump();
        n = 0;
        nvalid = 0;
        while (exp_q.size() > 0 && n < 40) begin
            tick();
            n++;
            if (rf.dump_valid) nvalid++;
            if (rf.dump_valid && rf.dump_addr < 5'd31) check("dump_busy_mid", WIDTH'(rf.dump_busy), 32'd1);
            dump_step();
            if (rf.dump_valid && rf.dump_addr == 5'd4) begin
                rf.RegWrite      = 1'b1;
                rf.WriteRegister = 5'd5;
                rf.WriteData     = 32'd500;
            end else if (rf.dump_valid && rf.dump_addr == 5'd5) begin
                rf.RegWrite = 1'b0;
                model[5] = 32'd500;
            end
        end
        check("dump1_timeout_left", WIDTH'(exp_q.size()), '0);
        check("dump1_valid_cycles", WIDTH'(nvalid), 32'd32);
        check("dump1_end_busy", WIDTH'(rf.dump_busy), '0);
        tick();
        check("dump1_after_valid", WIDTH'(rf.dump_valid), '0);
        check("dump1_after_busy",  WIDTH'(rf.dump_busy),  '0);
        check("dump1_hold_addr",   WIDTH'(rf.dump_addr),  32'd31);
        check("dump1_hold_data",   rf.dump_data,          32'd93);
        rf.ReadRegister1 = 5'd5;
        #1;
        check("collide_rd5", rf.ReadData1, 32'd500);

        // Held dump_req: full stream, one idle beat, restart, then reset mid-dump.
        rf.dump_req = 1'b1;
        tick();
        check("dump2_start_busy", WIDTH'(rf.dump_busy), 32'd1);
        push_dump();
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            tick();
            n++;
            dump_step();
        end
        check("dump2_timeout_left", WIDTH'(exp_q.size()), '0);
        tick();
        check("restart_gap_valid", WIDTH'(rf.dump_valid), '0);
        check("restart_gap_busy",  WIDTH'(rf.dump_busy),  32'd1);
        push_dump();
        n = 0;
        while (!(rf.dump_valid && rf.dump_addr == 5'd10) && n < 20) begin
            tick();
            n++;
            dump_step();
        end
        check("reach_addr10", WIDTH'(rf.dump_addr), 32'd10);
        reset = 1'b1;
        tick();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        check("midrst_valid", WIDTH'(rf.dump_valid), '0);
        check("midrst_busy",  WIDTH'(rf.dump_busy),  '0);
        check("midrst_addr",  WIDTH'(rf.dump_addr),  '0);
        check("midrst_data",  rf.dump_data,          '0);
        reset       = 1'b0;
        rf.dump_req = 1'b0;
        check_all_zero("midrst");
        tick();
        check("post_rst_valid", WIDTH'(rf.dump_valid), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
